// File: rtl/addsub_serial_if.sv
// Start/busy/done handshake and operand/result bus for the serial add/sub.
// The requester drives operands and start; the datapath returns status, result and flags.
interface addsub_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             control_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             overflow_out;
    logic             zero_out;

    modport master (
        output start_in, a_in, b_in, control_in,
        input  busy_out, done_out, sum_out, carry_out, overflow_out, zero_out
    );

    modport slave (
        input  start_in, a_in, b_in, control_in,
        output busy_out, done_out, sum_out, carry_out, overflow_out, zero_out
    );
endinterface

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement adder/subtractor: DIGIT bits per cycle, LSB digit first,
// registered inter-digit carry, start/busy/done handshake with carry, overflow and zero flags.
module addsub_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    addsub_serial_if.slave bus
);

    generate
        if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("addsub_serial: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    localparam int unsigned N  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = $clog2(WIDTH) + 1;
    localparam int unsigned DW = DIGIT + 1;

    localparam logic [CW-1:0]    LAST_CNT   = CW'(N - 1);
    localparam logic [WIDTH-1:0] DIGIT_MASK = WIDTH'({DIGIT{1'b1}});

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DW-1:0]    digit_sum;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] sum_merged;

    // Operands shift right each RUN cycle so the active digit always sits at bit 0.
    always_comb begin
        digit_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DW'(carry_q);
        shamt      = SW'(count_q) * SW'(DIGIT);
        sum_merged = (sum_q & ~(DIGIT_MASK << shamt))
                   | (WIDTH'(digit_sum[DIGIT-1:0]) << shamt);
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_in) begin
                    a_d     = bus.a_in;
                    b_d     = bus.control_in ? ~bus.b_in : bus.b_in;
                    carry_d = bus.control_in;
                    count_d = '0;
                    busy_d  = 1'b1;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = sum_merged;
                carry_d = digit_sum[DIGIT];
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                count_d = count_q + CW'(1);
                if (count_q == LAST_CNT) begin
                    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
                    cout_d  = digit_sum[DIGIT];
                    ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ digit_sum[DIGIT-1] ^ digit_sum[DIGIT];
                    zero_d  = (sum_merged == '0);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy_out     = busy_q;
    assign bus.done_out     = done_q;
    assign bus.sum_out      = sum_q;
    assign bus.carry_out    = cout_q;
    assign bus.overflow_out = ovf_q;
    assign bus.zero_out     = zero_q;

endmodule
